plc_timer_bank: RTL
===================

PLC_TIMER_BANK -- requirements
Module: plc_timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: counter, reload and data width; SHALL be >= PRE_W+3.
REQ-003 SHALL have parameter PRE_W, default 6: prescaler select width.
REQ-004 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-005 SHALL have port CPU_Reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port TIMER_WE, input, 1: register write strobe.
REQ-007 SHALL have port TIMER_ADDR, input, $clog2(NCH)+2: {channel index, reg select[1:0]}.
REQ-008 SHALL have port TIMER_DATA, input, CNT_W: write data.
REQ-009 SHALL have port TIMER_RD_DATA, output, CNT_W: combinational read of the addressed register.
REQ-010 SHALL have port TIMER_OV, output, NCH: per-channel one-cycle overflow pulse.
REQ-011 SHALL have port TIMER_IRQ, output, 1: OR of (status flag AND IE) over all channels.

Function
REQ-012 Register map per channel, reg select: 0 CONFIG, 1 RELOAD, 2 COUNT, 3 STATUS (bit0 flag, write-1-to-clear).
REQ-013 CONFIG fields: bit0 EN, bit1 MODE (0 auto-reload, 1 one-shot), bit2 IE, bits[PRE_W+2:3] PRE; other bits read 0.
REQ-014 Writes take effect at the CLK edge where TIMER_WE=1; channel index >= NCH: write ignored, read returns 0.
REQ-015 Per channel prescaler: counter 0..PRE; tick asserted in the cycle it equals PRE, then wraps to 0; PRE=0 gives a tick every cycle.
REQ-016 EN=0: prescaler held at 0, COUNT holds value, no ticks; a CONFIG write setting EN clears the prescaler.
REQ-017 On tick with COUNT != all-ones: COUNT increments by 1.
REQ-018 On tick with COUNT == all-ones: COUNT loads RELOAD, TIMER_OV[ch] is 1 for exactly the following cycle, STATUS flag sets.
REQ-019 One-shot mode: on overflow EN clears in the same edge; auto-reload: EN unchanged.
REQ-020 Software COUNT write in a tick cycle: written value wins, no increment, no overflow.
REQ-021 STATUS write-1 and overflow in the same cycle: flag remains set.
REQ-022 RELOAD written in the overflow cycle: the old RELOAD value is loaded.
REQ-023 Channels SHALL be fully independent; simultaneous overflows on several channels SHALL all pulse in the same cycle.

Reset
REQ-024 CPU_Reset=1 at a CLK edge: all CONFIG, RELOAD, COUNT, prescaler, STATUS registers clear to 0; TIMER_OV=0, TIMER_IRQ=0.
REQ-025 Reset SHALL override any same-cycle write or tick; a pending OV pulse SHALL be cancelled.

Configuration
REQ-026 Macro TIMER_IRQ_EN defined: STATUS flags, IE and TIMER_IRQ behave per REQ-011/018/021.
REQ-027 Macro TIMER_IRQ_EN undefined: no flag/IE storage; STATUS and IE read 0; TIMER_IRQ tied 0; TIMER_OV unaffected.

Verification
REQ-028 ch0 RELOAD=0xFFFC, COUNT=0xFFFC, CONFIG EN=1 PRE=0 auto-reload -> TIMER_OV[0] pulses every 4 cycles, 1 cycle wide.
REQ-029 ch1 PRE=3, COUNT=0xFFFE, EN=1 -> COUNT steps every 4 cycles; OV[1] after 8 cycles; COUNT=RELOAD after.
REQ-030 ch2 one-shot, COUNT=0xFFFF, PRE=0, IE=1 -> single OV[2] pulse, EN reads 0, TIMER_IRQ=1 until STATUS write 1.
REQ-031 COUNT write 0x1234 in the tick cycle of ch0 at 0xFFFF -> COUNT=0x1234, no OV pulse.
REQ-032 CPU_Reset asserted in the overflow cycle -> TIMER_OV stays 0, all registers read 0 next cycle.
REQ-033 Rebuild without TIMER_IRQ_EN, repeat REQ-030 -> OV[2] pulses, TIMER_IRQ stays 0, STATUS reads 0.

Source files
------------

// File: rtl/plc_timer_bank.sv
// -----------------------------------------------------------------------------
// plc_timer_bank
//
// A bank of NCH independent up-counting timer channels. Each channel has a
// prescaler, a reload register and a free-running counter. On the counter's
// wrap past all-ones it reloads, emits a one-cycle overflow pulse and,
// optionally, raises an interrupt flag.
//
// Optional feature macro: TIMER_IRQ_EN
//   defined   : per-channel STATUS flag and CONFIG.IE are stored; TIMER_IRQ is
//               the OR of (flag AND IE) over all channels.
//   undefined : no flag/IE storage, STATUS and IE read 0, TIMER_IRQ is 0.
//
// Register map (per channel, TIMER_ADDR = {channel, sel[1:0]}):
//   0 CONFIG : bit0 EN, bit1 MODE (1 = one-shot), bit2 IE, bits[PRE_W+2:3] PRE
//   1 RELOAD : value loaded on overflow
//   2 COUNT  : current counter value
//   3 STATUS : bit0 overflow flag, write 1 to clear
//
// Ports:
//   CLK           in   clock, rising edge
//   CPU_Reset     in   synchronous active-high reset
//   TIMER_WE      in   register write strobe
//   TIMER_ADDR    in   {channel index, register select}
//   TIMER_DATA    in   write data
//   TIMER_RD_DATA out  combinational read of the addressed register
//   TIMER_OV      out  per-channel one-cycle overflow pulse (registered)
//   TIMER_IRQ     out  interrupt request (registered)
// -----------------------------------------------------------------------------
module plc_timer_bank #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int PRE_W = 6
) (
    input  logic                       CLK,
    input  logic                       CPU_Reset,
    input  logic                       TIMER_WE,
    input  logic [$clog2(NCH)+1:0]     TIMER_ADDR,
    input  logic [CNT_W-1:0]           TIMER_DATA,
    output logic [CNT_W-1:0]           TIMER_RD_DATA,
    output logic [NCH-1:0]             TIMER_OV,
    output logic                       TIMER_IRQ
);

    localparam int AW  = $clog2(NCH) + 2;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] REG_CFG = 2'd0;
    localparam logic [1:0] REG_RLD = 2'd1;
    localparam logic [1:0] REG_CNT = 2'd2;
    localparam logic [1:0] REG_STS = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- state
    logic [NCH-1:0]   en_q,   en_d;
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   ov_q,   ov_d;
    logic [PRE_W-1:0] pre_q    [NCH];
    logic [PRE_W-1:0] pre_d    [NCH];
    logic [PRE_W-1:0] pcnt_q   [NCH];
    logic [PRE_W-1:0] pcnt_d   [NCH];
    logic [CNT_W-1:0] reload_q [NCH];
    logic [CNT_W-1:0] reload_d [NCH];
    logic [CNT_W-1:0] count_q  [NCH];
    logic [CNT_W-1:0] count_d  [NCH];
`ifdef TIMER_IRQ_EN
    logic [NCH-1:0]   ie_q,   ie_d;
    logic [NCH-1:0]   flag_q, flag_d;
    logic             irq_q;
`endif

    // ------------------------------------------------------ address decode
    logic [CHW-1:0] ch_sel_s;
    logic [1:0]     reg_sel_s;
    logic           ch_valid_s;

    generate
        if (NCH > 1) begin : g_multi_ch
            assign ch_sel_s = TIMER_ADDR[AW-1:2];
        end else begin : g_single_ch
            assign ch_sel_s = 1'b0;
        end
    endgenerate

    assign reg_sel_s  = TIMER_ADDR[1:0];
    // Only reachable when NCH is not a power of two.
    assign ch_valid_s = (int'(ch_sel_s) < NCH);

    logic [NCH-1:0] cfg_wr_s, rld_wr_s, cnt_wr_s, sts_wr_s;
    logic [NCH-1:0] tick_s, ovf_s;

    // Per-channel write strobes, prescaler tick and overflow detection.
    always_comb begin
        cfg_wr_s = {NCH{1'b0}};
        rld_wr_s = {NCH{1'b0}};
        cnt_wr_s = {NCH{1'b0}};
        sts_wr_s = {NCH{1'b0}};
        tick_s   = {NCH{1'b0}};
        ovf_s    = {NCH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (TIMER_WE && ch_valid_s && (int'(ch_sel_s) == c)) begin
                cfg_wr_s[c] = (reg_sel_s == REG_CFG);
                rld_wr_s[c] = (reg_sel_s == REG_RLD);
                cnt_wr_s[c] = (reg_sel_s == REG_CNT);
                sts_wr_s[c] = (reg_sel_s == REG_STS);
            end else begin
                cfg_wr_s[c] = 1'b0;
                rld_wr_s[c] = 1'b0;
                cnt_wr_s[c] = 1'b0;
                sts_wr_s[c] = 1'b0;
            end
            tick_s[c] = en_q[c] && (pcnt_q[c] == pre_q[c]);
            // A software COUNT write in the same cycle suppresses the overflow.
            ovf_s[c]  = tick_s[c] && (count_q[c] == CNT_ONES) && !cnt_wr_s[c];
        end
    end

    // Next-state for every channel register.
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        ov_d   = ovf_s;
`ifdef TIMER_IRQ_EN
        ie_d   = ie_q;
        flag_d = flag_q;
`endif
        for (int c = 0; c < NCH; c++) begin
            pre_d[c]    = pre_q[c];
            pcnt_d[c]   = pcnt_q[c];
            reload_d[c] = reload_q[c];
            count_d[c]  = count_q[c];

            if (cfg_wr_s[c]) begin
                en_d[c]   = TIMER_DATA[0];
                mode_d[c] = TIMER_DATA[1];
                pre_d[c]  = TIMER_DATA[PRE_W+2:3];
`ifdef TIMER_IRQ_EN
                ie_d[c]   = TIMER_DATA[2];
`endif
            end else if (ovf_s[c] && mode_q[c]) begin
                en_d[c] = 1'b0;
            end else begin
                en_d[c] = en_q[c];
            end

            // Prescaler restarts on enable, on every tick and while disabled.
            if (!en_d[c] || (cfg_wr_s[c] && TIMER_DATA[0]) || tick_s[c]) begin
                pcnt_d[c] = {PRE_W{1'b0}};
            end else begin
                pcnt_d[c] = pcnt_q[c] + PRE_ONE;
            end

            // RELOAD written in the overflow cycle: old value is still loaded.
            if (rld_wr_s[c]) begin
                reload_d[c] = TIMER_DATA;
            end else begin
                reload_d[c] = reload_q[c];
            end

            if (cnt_wr_s[c]) begin
                count_d[c] = TIMER_DATA;
            end else if (ovf_s[c]) begin
                count_d[c] = reload_q[c];
            end else if (tick_s[c]) begin
                count_d[c] = count_q[c] + CNT_ONE;
            end else begin
                count_d[c] = count_q[c];
            end

`ifdef TIMER_IRQ_EN
            // Overflow wins over a same-cycle write-1-to-clear.
            if (ovf_s[c]) begin
                flag_d[c] = 1'b1;
            end else if (sts_wr_s[c] && TIMER_DATA[0]) begin
                flag_d[c] = 1'b0;
            end else begin
                flag_d[c] = flag_q[c];
            end
`endif
        end
    end

    // Channel register file with synchronous reset.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            en_q   <= {NCH{1'b0}};
            mode_q <= {NCH{1'b0}};
            ov_q   <= {NCH{1'b0}};
`ifdef TIMER_IRQ_EN
            ie_q   <= {NCH{1'b0}};
            flag_q <= {NCH{1'b0}};
            irq_q  <= 1'b0;
`endif
            for (int c = 0; c < NCH; c++) begin
                pre_q[c]    <= {PRE_W{1'b0}};
                pcnt_q[c]   <= {PRE_W{1'b0}};
                reload_q[c] <= {CNT_W{1'b0}};
                count_q[c]  <= {CNT_W{1'b0}};
            end
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            ov_q   <= ov_d;
`ifdef TIMER_IRQ_EN
            ie_q   <= ie_d;
            flag_q <= flag_d;
            // Registered from next-state so it tracks flag_q & ie_q exactly.
            irq_q  <= |(flag_d & ie_d);
`endif
            for (int c = 0; c < NCH; c++) begin
                pre_q[c]    <= pre_d[c];
                pcnt_q[c]   <= pcnt_d[c];
                reload_q[c] <= reload_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // Combinational register read-back.
    always_comb begin
        TIMER_RD_DATA = {CNT_W{1'b0}};
        if (ch_valid_s) begin
            case (reg_sel_s)
                REG_CFG: begin
                    TIMER_RD_DATA[0]         = en_q[ch_sel_s];
                    TIMER_RD_DATA[1]         = mode_q[ch_sel_s];
`ifdef TIMER_IRQ_EN
                    TIMER_RD_DATA[2]         = ie_q[ch_sel_s];
`endif
                    TIMER_RD_DATA[PRE_W+2:3] = pre_q[ch_sel_s];
                end
                REG_RLD: TIMER_RD_DATA = reload_q[ch_sel_s];
                REG_CNT: TIMER_RD_DATA = count_q[ch_sel_s];
                REG_STS: begin
`ifdef TIMER_IRQ_EN
                    TIMER_RD_DATA[0] = flag_q[ch_sel_s];
`else
                    TIMER_RD_DATA[0] = 1'b0;
`endif
                end
                default: TIMER_RD_DATA = {CNT_W{1'b0}};
            endcase
        end else begin
            TIMER_RD_DATA = {CNT_W{1'b0}};
        end
    end

    assign TIMER_OV = ov_q;
`ifdef TIMER_IRQ_EN
    assign TIMER_IRQ = irq_q;
`else
    assign TIMER_IRQ = 1'b0;
`endif

endmodule
